// File: rtl/axi_interconnect_crossbar_mresp_merge_pkg.sv
// Shared definitions for the crossbar response-merge slice: request-entry field offsets,
// DECERR encoding, FSM state type and the width helper.
package axi_interconnect_crossbar_mresp_merge_pkg;

  localparam logic [1:0] RespDecerr = 2'b11;
  localparam int         LenW       = 8;

  typedef enum logic [1:0] {StIdle, StFwd, StDerr} state_e;

  // Bits needed to hold x; never less than 1 so single-entry indices stay legal.
  function automatic int log2(input int x);
    int r;
    r = 1;
    for (int i = 0; i < 31; i++) begin
      if (x >= (1 << i)) r = i + 1;
    end
    return r;
  endfunction

  // req_id is packed {decerr, master one-hot, slave idx, ID}.
  function automatic int sid_base(input int width_id);
    return width_id;
  endfunction

  function automatic int oh_base(input int width_id, input int width_sid);
    return width_id + width_sid;
  endfunction

  function automatic int decerr_pos(input int width_id, input int width_sid, input int num_master);
    return width_id + width_sid + num_master;
  endfunction

endpackage

// File: rtl/axi_interconnect_crossbar_mresp_merge_fifogen.sv
// Single-clock fall-through FIFO: rd_data shows the oldest entry, rd_en acknowledges it.
module axi_interconnect_fifogen #(
  parameter int    PA_DW       = 16,
  parameter int    PB_DW       = 16,
  parameter int    PA_AW       = 2,
  parameter string RD_AS_ACK   = "TRUE",
  parameter string CLOCK_ASYNC = "FALSE"
) (
  input  logic             clk_sys,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [PA_DW-1:0] wr_data,
  input  logic             rd_en,
  output logic [PB_DW-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int Depth = 1 << PA_AW;

  if (PA_DW != PB_DW || RD_AS_ACK != "TRUE" || CLOCK_ASYNC != "FALSE") begin : g_param_check
    $error("axi_interconnect_fifogen: only symmetric, read-as-ack, single-clock supported");
  end

  logic [PA_DW-1:0] mem_q [Depth];
  logic [PA_AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [PA_AW:0]   cnt_q, cnt_d;
  logic             full_q;
  logic             do_wr, do_rd;

  assign empty   = (cnt_q == '0);
  assign full    = full_q;
  assign do_rd   = rd_en && !empty;
  // A write into a full queue is allowed only when an entry leaves on the same edge.
  assign do_wr   = wr_en && (!full_q || do_rd);
  assign rd_data = mem_q[rd_ptr_q];

  always_comb begin
    cnt_d = cnt_q;
    if (do_wr && !do_rd) begin
      cnt_d = cnt_q + (PA_AW + 1)'(1);
    end else if (!do_wr && do_rd) begin
      cnt_d = cnt_q - (PA_AW + 1)'(1);
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
    end else begin
      if (do_wr) wr_ptr_q <= wr_ptr_q + PA_AW'(1);
      if (do_rd) rd_ptr_q <= rd_ptr_q + PA_AW'(1);
      cnt_q  <= cnt_d;
      full_q <= (cnt_d == {1'b1, {PA_AW{1'b0}}});
    end
  end

  always_ff @(posedge clk_sys) begin
    if (do_wr) mem_q[wr_ptr_q] <= wr_data;
  end

endmodule

// File: rtl/axi_interconnect_crossbar_mresp_merge.sv
// In-order response merge for one upstream slave port: follows the oldest routed request,
// passes the owning master's R/B beats through with the original ID, or fabricates DECERR.
module axi_interconnect_crossbar_mresp_merge
  import axi_interconnect_crossbar_mresp_merge_pkg::*;
#(
  parameter int MODE_READ         = 1,
  parameter int NUM_SLAVE         = 1,
  parameter int NUM_MASTER        = 1,
  parameter int WIDTH_ID          = 4,
  parameter int WIDTH_RESPINFO    = 35,
  parameter int NUM_OUTSTANDING   = 4,
  parameter int WIDTH_OUTSTANDING = log2(NUM_OUTSTANDING - 1),
  parameter int WIDTH_SALVE       = log2(NUM_SLAVE - 1),
  parameter int U_DLY             = 1
) (
  input  logic                                      clk_sys,
  input  logic                                      rst_n,
  input  logic                                      req_wren,
  input  logic [NUM_MASTER+WIDTH_SALVE+WIDTH_ID:0]  req_id,
  input  logic [7:0]                                req_len,
  output logic                                      req_full,
  output logic                                      req_ovf,
  input  logic [NUM_MASTER*WIDTH_RESPINFO-1:0]      m_resp_info,
  input  logic [NUM_MASTER-1:0]                     m_resp_valid,
  output logic [NUM_MASTER-1:0]                     m_resp_ready,
  output logic [WIDTH_ID+WIDTH_RESPINFO-1:0]        resp_info,
  output logic [WIDTH_SALVE-1:0]                    resp_sid,
  output logic                                      resp_valid,
  input  logic                                      resp_ready
);

  localparam int ReqW      = NUM_MASTER + WIDTH_SALVE + WIDTH_ID + 1;
  localparam int EntW      = ReqW + LenW;
  localparam int SidBase   = sid_base(WIDTH_ID);
  localparam int OhBase    = oh_base(WIDTH_ID, WIDTH_SALVE);
  localparam int DecerrPos = decerr_pos(WIDTH_ID, WIDTH_SALVE, NUM_MASTER);

  if (NUM_MASTER < 1 || NUM_MASTER > 4 || NUM_SLAVE < 1 || U_DLY < 0 ||
      NUM_OUTSTANDING != (1 << WIDTH_OUTSTANDING)) begin : g_param_check
    $error("axi_interconnect_crossbar_mresp_merge: unsupported parameter set");
  end

  logic [EntW-1:0]           fifo_rdata;
  logic                      fifo_empty, fifo_full;
  logic [ReqW-1:0]           ent_req;
  logic [LenW-1:0]           ent_len;
  logic                      ent_derr;
  logic                      pop, hs, last_beat, txn_end;
  logic [WIDTH_RESPINFO-1:0] payload;

  state_e            state_q;
  logic [ReqW-2:0]   head_q;
  logic [LenW-1:0]   cnt_q;
  logic              ovf_q;

  logic [WIDTH_ID-1:0]    head_id;
  logic [WIDTH_SALVE-1:0] head_sid;
  logic [NUM_MASTER-1:0]  head_oh;

  axi_interconnect_fifogen #(
    .PA_DW       (EntW),
    .PB_DW       (EntW),
    .PA_AW       (WIDTH_OUTSTANDING),
    .RD_AS_ACK   ("TRUE"),
    .CLOCK_ASYNC ("FALSE")
  ) u_req_fifo (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .wr_en   (req_wren),
    .wr_data ({req_id, req_len}),
    .rd_en   (pop),
    .rd_data (fifo_rdata),
    .empty   (fifo_empty),
    .full    (fifo_full)
  );

  assign ent_req  = fifo_rdata[EntW-1:LenW];
  assign ent_len  = fifo_rdata[LenW-1:0];
  // An empty one-hot would never be answered by any master, so it is answered locally.
  assign ent_derr = ent_req[DecerrPos] || (ent_req[OhBase +: NUM_MASTER] == '0);

  assign head_id  = head_q[WIDTH_ID-1:0];
  assign head_sid = head_q[SidBase +: WIDTH_SALVE];
  assign head_oh  = head_q[OhBase +: NUM_MASTER];

  always_comb begin
    payload      = '0;
    resp_valid   = 1'b0;
    m_resp_ready = '0;
    last_beat    = 1'b0;
    case (state_q)
      StFwd: begin
        // Descending scan so the lowest set bit is the one finally selected.
        for (int i = NUM_MASTER - 1; i >= 0; i--) begin
          if (head_oh[i]) begin
            payload         = m_resp_info[i*WIDTH_RESPINFO +: WIDTH_RESPINFO];
            resp_valid      = m_resp_valid[i];
            m_resp_ready    = '0;
            m_resp_ready[i] = resp_ready;
          end
        end
        last_beat = (MODE_READ == 0) || payload[WIDTH_RESPINFO-1];
      end
      StDerr: begin
        resp_valid   = 1'b1;
        payload[1:0] = RespDecerr;
        if (MODE_READ != 0) payload[WIDTH_RESPINFO-1] = (cnt_q == '0);
        last_beat = (MODE_READ == 0) || (cnt_q == '0);
      end
      default: ;
    endcase
  end

  assign hs        = resp_valid && resp_ready;
  assign txn_end   = hs && last_beat;
  assign pop       = !fifo_empty && ((state_q == StIdle) || txn_end);
  assign resp_info = (state_q == StIdle) ? '0 : {head_id, payload};
  assign resp_sid  = (state_q == StIdle) ? '0 : head_sid;
  assign req_full  = fifo_full;
  assign req_ovf   = ovf_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      head_q  <= '0;
      cnt_q   <= '0;
    end else if (pop) begin
      state_q <= ent_derr ? StDerr : StFwd;
      head_q  <= ent_req[ReqW-2:0];
      cnt_q   <= ent_len;
    end else if (txn_end) begin
      state_q <= StIdle;
    end else if ((state_q == StDerr) && hs) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
    end else if (req_wren && fifo_full && !pop) begin
      ovf_q <= 1'b1;
    end
  end

endmodule
